// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int BLOCK_BITS      = 512;
  localparam int BLOCK_BYTES     = 64;
  localparam int LEN_FIELD_BYTES = 8;
  localparam int MAX_TAIL_BYTES  = 55;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    OUT,
    PAD
  } padder_state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and padded-block output of the SHA-256 message padder.
interface sha256_msg_padder_if #(
  parameter int BYTES_PER_BEAT = 1
);
  localparam int IBW = $clog2(BYTES_PER_BEAT + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [8*BYTES_PER_BEAT-1:0] in_data;
  logic                        in_last;
  logic [IBW-1:0]              in_bytes;
  logic                        blk_valid;
  logic                        blk_ready;
  logic [511:0]                blk_data;
  logic                        blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/sha256_block_buffer.sv
// 64-byte block register: per-byte writes, bulk clear, and a length-field
// write into bytes 56..63 that takes priority over the byte writes.
module sha256_block_buffer
  import sha256_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [BLOCK_BYTES-1:0]             byte_we,
  input  logic [0:BLOCK_BYTES-1][7:0]        byte_wd,
  input  logic                               len_we,
  input  logic [63:0]                        len_val,
  output logic [BLOCK_BITS-1:0]              data
);

  localparam int LEN_BASE = BLOCK_BYTES - LEN_FIELD_BYTES;

  // Byte 0 is the leftmost element, so it lands in data[511:504].
  logic [0:BLOCK_BYTES-1][7:0] mem;

  // NOTE: this storage is reset because blk_data must read zero out of reset
  // and a mid-message reset must discard the partial block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (len_we && i >= LEN_BASE)
          mem[i] <= len_val[8*(BLOCK_BYTES-1-i) +: 8];
        else if (byte_we[i])
          mem[i] <= byte_wd[i];
        else if (clr)
          mem[i] <= '0;
      end
    end
  end

  assign data = mem;

endmodule

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 pre-processor: packs message bytes into 512-bit blocks
// and appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int BYTES_PER_BEAT = 1,
  parameter int LEN_W          = 64
) (
  input  logic                clk,
  input  logic                rst,
  sha256_msg_padder_if.slave  bus,
  output logic                busy
);

  localparam int IBW = $clog2(BYTES_PER_BEAT + 1);
  localparam int BW  = 8 * BYTES_PER_BEAT;

  padder_state_t state, state_nxt;
  logic [6:0]       ptr, ptr_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             pad_pend, pad_pend_nxt;
  logic             len_pend, len_pend_nxt;
  logic             blk_last_q, blk_last_nxt;

  logic [6:0]       n, p;
  logic [LEN_W-1:0] len_sum;
  logic [BW-1:0]    beat_sh;

  logic                        clr, len_we;
  logic [BLOCK_BYTES-1:0]      byte_we;
  logic [0:BLOCK_BYTES-1][7:0] byte_wd;
  logic [63:0]                 len_val;

  assign n = !bus.in_last                          ? 7'(BYTES_PER_BEAT) :
             (bus.in_bytes > IBW'(BYTES_PER_BEAT)) ? 7'(BYTES_PER_BEAT) :
                                                     7'(bus.in_bytes);
  assign p       = ptr + n;
  assign len_sum = len + (LEN_W'(n) << 3);

  // NOTE: every signal driven here gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    len_nxt      = len;
    pad_pend_nxt = pad_pend;
    len_pend_nxt = len_pend;
    blk_last_nxt = blk_last_q;
    clr          = 1'b0;
    len_we       = 1'b0;
    len_val      = 64'(len);
    byte_we      = '0;
    byte_wd      = '0;
    beat_sh      = '0;

    unique case (state)
      FILL: begin
        if (bus.in_valid) begin
          ptr_nxt = p;
          len_nxt = len_sum;
          // Beat bytes fill [ptr, p); a last beat also gets the marker at p
          // and zeros after it.
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= int'(ptr) && i < int'(p)) begin
              beat_sh    = bus.in_data << (8 * (i - int'(ptr)));
              byte_we[i] = 1'b1;
              byte_wd[i] = beat_sh[BW-1 -: 8];
            end else if (bus.in_last && i == int'(p)) begin
              byte_we[i] = 1'b1;
              byte_wd[i] = PAD_BYTE;
            end else if (bus.in_last && i > int'(p)) begin
              byte_we[i] = 1'b1;
            end
          end
          if (!bus.in_last) begin
            if (p == 7'(BLOCK_BYTES)) begin
              state_nxt    = OUT;
              blk_last_nxt = 1'b0;
              ptr_nxt      = '0;
            end
          end else begin
            state_nxt = OUT;
            ptr_nxt   = '0;
            if (p == 7'(BLOCK_BYTES)) begin
              blk_last_nxt = 1'b0;
              pad_pend_nxt = 1'b1;
              len_pend_nxt = 1'b1;
            end else if (p <= 7'(MAX_TAIL_BYTES)) begin
              blk_last_nxt = 1'b1;
              len_we       = 1'b1;
              len_val      = 64'(len_sum);
            end else begin
              blk_last_nxt = 1'b0;
              len_pend_nxt = 1'b1;
            end
          end
        end
      end

      OUT: begin
        if (bus.blk_ready) begin
          clr = 1'b1;
          if (blk_last_q) begin
            state_nxt    = FILL;
            ptr_nxt      = '0;
            len_nxt      = '0;
            pad_pend_nxt = 1'b0;
            len_pend_nxt = 1'b0;
            blk_last_nxt = 1'b0;
          end else if (pad_pend || len_pend) begin
            state_nxt = PAD;
          end else begin
            state_nxt = FILL;
          end
        end
      end

      PAD: begin
        clr          = 1'b1;
        byte_we[0]   = 1'b1;
        byte_wd[0]   = pad_pend ? PAD_BYTE : 8'h00;
        len_we       = 1'b1;
        state_nxt    = OUT;
        blk_last_nxt = 1'b1;
        pad_pend_nxt = 1'b0;
        len_pend_nxt = 1'b0;
      end

      default: state_nxt = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      ptr        <= '0;
      len        <= '0;
      pad_pend   <= 1'b0;
      len_pend   <= 1'b0;
      blk_last_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      len        <= len_nxt;
      pad_pend   <= pad_pend_nxt;
      len_pend   <= len_pend_nxt;
      blk_last_q <= blk_last_nxt;
    end
  end

  sha256_block_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .byte_we (byte_we),
    .byte_wd (byte_wd),
    .len_we  (len_we),
    .len_val (len_val),
    .data    (bus.blk_data)
  );

  assign bus.in_ready  = (state == FILL);
  assign bus.blk_valid = (state == OUT);
  assign bus.blk_last  = blk_last_q;
  assign busy          = (ptr != '0) || (state != FILL);

endmodule
